// File: rtl/tcdm_sched_pkg.sv
// Shared types and constants for the TCDM per-bank scheduler.
package tcdm_sched_pkg;

  // Pipe-mode sequencing states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sched_state_t;

  // Width of the optional stall counter.
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/tcdm_rr_arb.sv
// N-way round-robin picker: grants the first eligible requester at or after
// the current priority index, wrapping, and moves priority past the winner.
module tcdm_rr_arb
  import tcdm_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] elig_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] prio_q, prio_d;
  int            best;
  int            best_off;
  int            off;

  // Pick the eligible requester with the smallest wrapped distance from prio_q.
  always_comb begin
    gnt_o    = '0;
    prio_d   = prio_q;
    best     = 0;
    best_off = N;
    off      = 0;
    for (int j = 0; j < N; j++) begin
      off = (j + N - int'(prio_q)) % N;
      if (elig_i[j] && (off < best_off)) begin
        best_off = off;
        best     = j;
      end
    end
    for (int j = 0; j < N; j++) begin
      if ((best_off < N) && (best == j)) gnt_o[j] = 1'b1;
    end
    if (best_off < N) prio_d = PW'((best + 1) % N);
  end

  // Priority pointer; holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= '0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/tcdm_bank_sched.sv
// Per-bank TCDM request scheduler: round-robin arbitration of N_MASTER
// requesters onto one SCM+SRAM bank, SCM-after-SRAM collision avoidance when
// the SRAM pipe is on, and drain-then-switch sequencing of the pipe mode.
// Optional feature macro: TCDM_SCHED_STATS_EN adds the stall_cnt_o counter.
module tcdm_bank_sched
  import tcdm_sched_pkg::*;
#(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int SCM_WORDS  = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_MASTER-1:0]                      req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]      add_i,
  input  logic [N_MASTER-1:0]                      wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH/8-1:0]    be_i,
  output logic [N_MASTER-1:0]                      gnt_o,
  output logic                                     bank_req_o,
  output logic [ADDR_WIDTH-1:0]                    bank_add_o,
  output logic                                     bank_wen_o,
  output logic [DATA_WIDTH-1:0]                    bank_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  bank_be_o,
  output logic                                     bank_sel_o,
  output logic [N_MASTER-1:0]                      bank_id_o,
  input  logic                                     pipe_en_cfg_i,
  output logic                                     pipe_en_o
`ifdef TCDM_SCHED_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]                   stall_cnt_o
`endif
);

  sched_state_t          state_q;
  logic [1:0]            hist_q;
  logic                  sram_granted_q;
  logic                  pipe_en_q;
  logic [N_MASTER-1:0]   sram_m;
  logic [N_MASTER-1:0]   elig;
  logic [N_MASTER-1:0]   gnt;
  logic                  block_all;
  logic                  block_scm;

  assign pipe_en_o = pipe_en_q;
  // Any mismatch between requested and applied mode stops grants immediately.
  assign block_all = (state_q != RUN) || (pipe_en_cfg_i != pipe_en_q);
  // With the pipe on, an SCM grant right after an SRAM grant would return data
  // in the same cycle; SRAM requests stay eligible.
  assign block_scm = pipe_en_q & sram_granted_q;

  // Region decode and eligibility per master.
  always_comb begin
    sram_m = '0;
    elig   = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      sram_m[m] = (int'(add_i[m]) >= SCM_WORDS);
      elig[m]   = req_i[m] & ~block_all & ~(block_scm & ~sram_m[m]);
    end
  end

  tcdm_rr_arb #(.N(N_MASTER)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  // Bank-side fields of the granted master; all zero without a grant.
  always_comb begin
    bank_add_o   = '0;
    bank_wen_o   = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      if (gnt[m]) begin
        bank_add_o   = add_i[m];
        bank_wen_o   = wen_i[m];
        bank_wdata_o = wdata_i[m];
        bank_be_o    = be_i[m];
      end
    end
  end

  assign gnt_o      = gnt;
  assign bank_id_o  = gnt;
  assign bank_req_o = |gnt;
  assign bank_sel_o = |(gnt & sram_m);

  // Grant history, SRAM-grant flag and mode sequencing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pipe_en_q      <= 1'b0;
      hist_q         <= 2'b00;
      sram_granted_q <= 1'b0;
    end else begin
      hist_q         <= {hist_q[0], |gnt};
      sram_granted_q <= |(gnt & sram_m);
      case (state_q)
        RUN:    if (pipe_en_cfg_i != pipe_en_q) state_q <= DRAIN;
        DRAIN:  if (hist_q == 2'b00) state_q <= SWITCH;
        SWITCH: begin
          pipe_en_q      <= pipe_en_cfg_i;
          sram_granted_q <= 1'b0;
          state_q        <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef TCDM_SCHED_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles with pending requests but no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else if ((|req_i) && !(|gnt) && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/tcdm_bank_sched.md
# tcdm_bank_sched

Per-bank request scheduler for the cluster TCDM. It shares one TCDM bank (SCM region plus SRAM region) among `N_MASTER` requesters using round-robin arbitration, and drives the bank-side request, region select and one-hot response ID into the bank response pipe stage. It also sequences that stage's SRAM pipe enable:
- It suppresses grants that would make SCM and SRAM responses land in the same cycle.
- It drains in-flight accesses before the pipe mode changes.

## Interface
- `N_MASTER`, 4, number of requesters (≥2).
- `ADDR_WIDTH`, 12, bank word-address width.
- `DATA_WIDTH`, 32, write-data width.
- `SCM_WORDS`, 256, word addresses below this value hit the SCM; addresses at or above it hit the SRAM.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req_i`  in  N_MASTER  per-master request.
- `add_i`  in  N_MASTER×ADDR_WIDTH  per-master word address.
- `wen_i`  in  N_MASTER  per-master write-enable-low (1 = read).
- `wdata_i`  in  N_MASTER×DATA_WIDTH  per-master write data.
- `be_i`  in  N_MASTER×DATA_WIDTH/8  per-master byte enables.
- `gnt_o`  out  N_MASTER  one-hot grant, combinational.
- `bank_req_o`  out  1  request to bank.
- `bank_add_o`, `bank_wen_o`, `bank_wdata_o`, `bank_be_o`  out  (as above)  muxed fields of the granted master.
- `bank_sel_o`  out  1  region select (1 = SRAM).
- `bank_id_o`  out  N_MASTER  one-hot ID of the granted master.
- `pipe_en_cfg_i`  in  1  requested SRAM pipe mode (quasi-static).
- `pipe_en_o`  out  1  applied SRAM pipe mode, registered.

## Operation
- Region decode per master: `sram_m = (add_i[m] >= SCM_WORDS)`.
- Eligibility:
  - `elig[m] = req_i[m] & ~block_all & ~(block_scm & ~sram_m)`.
  - `block_scm = pipe_en_o & sram_granted_q`, where `sram_granted_q` is a register that is set when an SRAM grant was issued in the previous cycle.
  - Reason for `block_scm`: with the pipe on, SRAM data returns 2 cycles after the grant and SCM data returns 1 cycle after the grant, so an SCM grant in the cycle after an SRAM grant would collide. SRAM requests are still eligible in that cycle.
- Round-robin arbitration:
  - `prio_q` is the index of the highest-priority master; search is ascending and wraps modulo `N_MASTER`.
  - On a grant to master k, `prio_q <= (k+1) mod N_MASTER`.
  - `prio_q` is unchanged when no grant is issued.
- `bank_req_o = |gnt_o`. The bank fields, `bank_sel_o` and `bank_id_o = gnt_o` all come from the granted master; with no grant they are all zero.
- Grant history `hist_q[1:0]`: `hist_q[0] <= |gnt_o`, `hist_q[1] <= hist_q[0]`.
- Mode FSM (states RUN, DRAIN, SWITCH):
  - RUN: `block_all = (pipe_en_cfg_i != pipe_en_o)`. If they differ, go to DRAIN.
  - DRAIN: `block_all = 1`. When `hist_q == 0`, go to SWITCH.
  - SWITCH: `block_all = 1`. Set `pipe_en_o <= pipe_en_cfg_i`; clear `sram_granted_q`; go to RUN.
  - If `pipe_en_cfg_i` reverts during DRAIN, the FSM still passes through SWITCH; the update is then a no-op.
- Reset values:
  - Outputs: all zero. `pipe_en_o = 0`.
  - Internal state: FSM = RUN, `prio_q = 0`, `hist_q = 0`, `sram_granted_q = 0`.
  - Reset asserted mid-drain returns the FSM to RUN with the pipe off.

## Timing
- Grant is combinational from `req_i` in the same cycle; the bank request is issued in that cycle.
- Response at the response stage arrives:
  - SCM: at grant+1.
  - SRAM with the pipe off: at grant+1.
  - SRAM with the pipe on: at grant+2.
- A mode change first observed in cycle t:
  - Grants are blocked from t.
  - The FSM enters DRAIN at t+1.
  - DRAIN exits once both history bits have cleared: worst case SWITCH at t+3 (last grant at t−1).
  - `pipe_en_o` is updated at the end of SWITCH; RUN resumes the next cycle with the new mode, worst case t+4.
- Requesters hold `req_i` and the request fields until granted. Deasserting `req_i` while ungranted is allowed and has no side effect.

## Configuration
- `TCDM_SCHED_STATS_EN`:
  - Defined: adds output `stall_cnt_o[15:0]`.
    - Increments by one for every cycle in which at least one request is pending and no grant is issued (counts both `block_scm` and `block_all` stalls).
    - Saturates at 0xFFFF; reset value 0.
  - Undefined: the port and counter do not exist; scheduling behaviour is identical.

## Structure
- `tcdm_sched_pkg`:
  - `sched_state_t` enum (RUN, DRAIN, SWITCH).
  - The `stall_cnt_o` width constant (16).
- Sub-module `tcdm_rr_arb`: parameterized N-way round-robin picker holding `prio_q`, with inputs `elig` and outputs one-hot `gnt`. All address decode, muxing, blocking and the FSM stay in `tcdm_bank_sched`.

## Test plan
- Round-robin fairness: masters 0–3 request continuously, pipe off, all SCM addresses → grants issued 0,1,2,3,0 on consecutive cycles; `bank_sel_o = 0`.
- SRAM-then-SCM collision with the pipe on:
  - m0 requests address 0x100 at t; m1 requests address 0x010 at t and t+1.
  - Expected: m0 granted at t; no grant at t+1 (with `TCDM_SCHED_STATS_EN` defined, `stall_cnt_o = 1`); m1 granted at t+2.
- Same stimulus with the pipe off → m0 granted at t, m1 granted at t+1; no stall.
- Mode switch:
  - Last grant at t−1; `pipe_en_cfg_i` toggles 0→1 at t; requests held throughout.
  - Expected: no grants t..t+3; `pipe_en_o = 1` and grants resume at t+4.
- Reset mid-DRAIN: assert `rst` at t+1 → all outputs 0 and `pipe_en_o = 0`. After release, the FSM returns to RUN, sees `pipe_en_cfg_i = 1`, and repeats the drain sequence.
- SRAM back-to-back with the pipe on: m0 and m1 both request SRAM addresses 0x200 and 0x300 → granted on consecutive cycles with no stall.
